// File: rtl/hcf_pkg.sv
// Shared types and defaults for the HCF operand sequencer.
package hcf_pkg;

  localparam int HCF_WIDTH   = 16;
  localparam int HCF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_RUN    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_CLEAR  = 3'd5
  } hcf_seq_state_t;

  // A zero operand never terminates the core's subtract loop, so it is answered locally.
  function automatic logic is_bypass(input logic a_zero, input logic b_zero);
    return a_zero | b_zero;
  endfunction

endpackage

// File: rtl/hcf_cycle_counter.sv
// Up-counter with clear and enable; term flags the count TIMEOUT-1.
module hcf_cycle_counter #(
  parameter int TIMEOUT = 1024,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CW-1:0] cnt;

  assign term = (cnt == CW'(TIMEOUT - 1));

  // Holding at the terminal value keeps the count in range even if enable lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hcf_operand_sequencer.sv
// Feeds an operand pair to the HCF core over its shared data bus and returns the result.
// state   | meaning
// IDLE    | accept a new operand pair
// LOAD_A  | drive A, pulse core_start
// LOAD_B  | drive B, zero the cycle counter
// RUN     | wait for core_done or timeout
// HOLD    | present result until out_ready
// CLEAR   | return the core to its load-A state
module hcf_operand_sequencer
  import hcf_pkg::*;
#(
  parameter int WIDTH   = HCF_WIDTH,
  parameter int TIMEOUT = HCF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] core_data,
  output logic             core_start,
  output logic             core_clr,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hcf,
  output logic             out_err,
  output logic             busy
);

  hcf_seq_state_t state_q, state_d;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             a_zero, b_zero, bypass, accept;
  logic             cnt_clr, cnt_en, cnt_term;
  logic             idle_ready, clr_fsm;

  assign a_zero = (in_a == '0);
  assign b_zero = (in_b == '0);
  assign bypass = is_bypass(a_zero, b_zero);
  assign accept = (state_q == ST_IDLE) && in_valid;

  hcf_cycle_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_ready = 1'b0;
    core_data  = '0;
    core_start = 1'b0;
    clr_fsm    = 1'b0;
    out_valid  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (in_valid) begin
          state_d = bypass ? ST_HOLD : ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        core_data  = a_reg;
        core_start = 1'b1;
        state_d    = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        core_data = b_reg;
        cnt_clr   = 1'b1;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (core_done || cnt_term) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_fsm = 1'b1;
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The core is held cleared for as long as reset is asserted.
  assign core_clr = clr_fsm | rst;
  assign in_ready = idle_ready & ~rst;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      out_hcf <= '0;
      out_err <= 1'b0;
    end else begin
      if (accept) begin
        a_reg <= in_a;
        b_reg <= in_b;
        if (bypass) begin
          out_hcf <= in_a | in_b;
          out_err <= a_zero & b_zero;
        end
      end
      // core_done wins over a timeout landing in the same cycle.
      if (state_q == ST_RUN) begin
        if (core_done) begin
          out_hcf <= core_result;
          out_err <= 1'b0;
        end else if (cnt_term) begin
          out_hcf <= '0;
          out_err <= 1'b1;
        end
      end
    end
  end

endmodule
